// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared widths, ALU operation encodings and the control bundle
//            carried by the ID/EX pipeline register.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;

    // ALU operation encodings
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 4'h0;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 4'h1;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'h2;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 4'h6;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT = 4'h7;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR = 4'hC;

    // Control bits that travel with an instruction from ID into EX
    typedef struct packed {
        logic               alusrc;
        logic               regdst;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    // A bubble carries no side effects: every control bit is zero
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/wb_bypass_sel.sv
`default_nettype none
// ============================================================================
// Module   : wb_bypass_sel
// Brief    : Compares the write-back destination against one register
//            specifier and substitutes the write-back data on a hit.
//            Register 0 is hard-wired to zero and is never bypassed.
// Revision : 1.0  initial release
// ============================================================================
module wb_bypass_sel #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_wb_regwrite,
    input  logic [REG_ADDR_W-1:0] i_wb_writereg,
    input  logic [DATA_W-1:0]     i_wb_writedata,
    input  logic [REG_ADDR_W-1:0] i_spec,
    input  logic [DATA_W-1:0]     i_data,
    output logic [DATA_W-1:0]     o_data
);

    logic w_hit;

    // A hit needs an enabled write to a non-zero register matching the specifier
    assign w_hit  = i_wb_regwrite && (i_wb_writereg != '0) && (i_wb_writereg == i_spec);
    assign o_data = w_hit ? i_wb_writedata : i_data;

endmodule : wb_bypass_sel
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register with stall (hold), flush (bubble) and a
//            write-back bypass applied both when loading and while holding.
//            Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush
//            event counters (StallCount, FlushCount).
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = pipe_pkg::ALUOP_W
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ID_Valid,
    input  logic [DATA_W-1:0]     ID_PC,
    input  logic [DATA_W-1:0]     ID_ReadData1,
    input  logic [DATA_W-1:0]     ID_ReadData2,
    input  logic [DATA_W-1:0]     ID_Imm,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic [REG_ADDR_W-1:0] ID_Rd,
    input  logic                  ID_ALUSrc,
    input  logic                  ID_RegDst,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemToReg,
    input  logic [ALUOP_W-1:0]    ID_ALUOp,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteReg,
    input  logic [DATA_W-1:0]     WB_WriteData,
    output logic                  EX_Valid,
    output logic [DATA_W-1:0]     EX_PC,
    output logic [DATA_W-1:0]     EX_ReadData1,
    output logic [DATA_W-1:0]     EX_ReadData2,
    output logic [DATA_W-1:0]     EX_Imm,
    output logic [REG_ADDR_W-1:0] EX_Rs,
    output logic [REG_ADDR_W-1:0] EX_Rt,
    output logic [REG_ADDR_W-1:0] EX_Rd,
    output logic                  EX_ALUSrc,
    output logic                  EX_RegDst,
    output logic                  EX_MemRead,
    output logic                  EX_MemWrite,
    output logic                  EX_RegWrite,
    output logic                  EX_MemToReg,
    output logic [ALUOP_W-1:0]    EX_ALUOp
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
`endif
);

    import pipe_pkg::*;

    logic                  r_valid;
    logic [DATA_W-1:0]     r_pc;
    logic [DATA_W-1:0]     r_rd1;
    logic [DATA_W-1:0]     r_rd2;
    logic [DATA_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_rd;
    ctrl_t                 r_ctrl;

    ctrl_t                 w_id_ctrl;
    logic [REG_ADDR_W-1:0] w_rs_spec;
    logic [REG_ADDR_W-1:0] w_rt_spec;
    logic [DATA_W-1:0]     w_rd1_src;
    logic [DATA_W-1:0]     w_rd2_src;
    logic [DATA_W-1:0]     w_rd1_byp;
    logic [DATA_W-1:0]     w_rd2_byp;

    assign w_id_ctrl = '{alusrc:   ID_ALUSrc,
                         regdst:   ID_RegDst,
                         memread:  ID_MemRead,
                         memwrite: ID_MemWrite,
                         regwrite: ID_RegWrite,
                         memtoreg: ID_MemToReg,
                         aluop:    ID_ALUOp};

    // While stalled the bypass watches the held specifiers/operands, otherwise
    // the incoming ID ones; this lets one comparator per operand serve both cases.
    assign w_rs_spec = Stall ? r_rs  : ID_Rs;
    assign w_rt_spec = Stall ? r_rt  : ID_Rt;
    assign w_rd1_src = Stall ? r_rd1 : ID_ReadData1;
    assign w_rd2_src = Stall ? r_rd2 : ID_ReadData2;

    wb_bypass_sel #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_rs (
        .i_wb_regwrite  (WB_RegWrite),
        .i_wb_writereg  (WB_WriteReg),
        .i_wb_writedata (WB_WriteData),
        .i_spec         (w_rs_spec),
        .i_data         (w_rd1_src),
        .o_data         (w_rd1_byp)
    );

    wb_bypass_sel #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_rt (
        .i_wb_regwrite  (WB_RegWrite),
        .i_wb_writereg  (WB_WriteReg),
        .i_wb_writedata (WB_WriteData),
        .i_spec         (w_rt_spec),
        .i_data         (w_rd2_src),
        .o_data         (w_rd2_byp)
    );

    // Pipeline register: flush beats stall; a stall only refreshes the operands
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= BUBBLE_CTRL;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= BUBBLE_CTRL;
        end else if (Stall) begin
            r_rd1   <= w_rd1_byp;
            r_rd2   <= w_rd2_byp;
        end else begin
            r_valid <= ID_Valid;
            r_pc    <= ID_PC;
            r_rd1   <= w_rd1_byp;
            r_rd2   <= w_rd2_byp;
            r_imm   <= ID_Imm;
            r_rs    <= ID_Rs;
            r_rt    <= ID_Rt;
            r_rd    <= ID_Rd;
            r_ctrl  <= w_id_ctrl;
        end
    end

    assign EX_Valid     = r_valid;
    assign EX_PC        = r_pc;
    assign EX_ReadData1 = r_rd1;
    assign EX_ReadData2 = r_rd2;
    assign EX_Imm       = r_imm;
    assign EX_Rs        = r_rs;
    assign EX_Rt        = r_rt;
    assign EX_Rd        = r_rd;
    assign EX_ALUSrc    = r_ctrl.alusrc;
    assign EX_RegDst    = r_ctrl.regdst;
    assign EX_MemRead   = r_ctrl.memread;
    assign EX_MemWrite  = r_ctrl.memwrite;
    assign EX_RegWrite  = r_ctrl.regwrite;
    assign EX_MemToReg  = r_ctrl.memtoreg;
    assign EX_ALUOp     = r_ctrl.aluop;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters; a flushed edge is never counted as a stall
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (Flush) begin
                if (r_flush_cnt != '1) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end else if (Stall) begin
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule : id_ex_pipe_reg
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath. Captures decoded operands and control at the end of ID and presents them to EX.
- Its EX_ReadData2, EX_Imm and EX_ALUSrc outputs drive the inA, inB and sel inputs of the 32-bit 2:1 ALU-source mux.
- Supports stall (hold), flush (bubble insertion) and a write-back bypass, so a register written in WB is never latched stale.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- REG_ADDR_W, 5, register-specifier width.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold current contents.
- Flush  in  1  load a bubble.
- ID_Valid  in  1  ID stage holds a real instruction.
- ID_PC  in  DATA_W  PC+4 of the ID instruction.
- ID_ReadData1 / ID_ReadData2  in  DATA_W  register-file read data for Rs / Rt.
- ID_Imm  in  DATA_W  sign-extended immediate.
- ID_Rs / ID_Rt / ID_Rd  in  REG_ADDR_W  register specifiers.
- ID_ALUSrc, ID_RegDst, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg  in  1 each  control bits.
- ID_ALUOp  in  ALUOP_W  ALU operation.
- WB_RegWrite  in  1  write-back enable.
- WB_WriteReg  in  REG_ADDR_W  write-back destination register.
- WB_WriteData  in  DATA_W  write-back data.
- EX_*  out  (same widths)  registered copies of every ID_* input above, including EX_Valid.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low (Reset_n); all outputs clear to 0 immediately on assertion.
- Latency: 1 cycle, ID inputs to EX outputs.
- Per-edge priority:
  - Reset_n low
  - Flush: bubble, i.e. every EX_* output is 0, including EX_Valid and all data fields.
  - Stall: hold.
  - Otherwise: load from ID.
- Flush and Stall asserted together: Flush wins.
- Write-back bypass on load: an RS hit is WB_RegWrite=1 && WB_WriteReg!=0 && WB_WriteReg==ID_Rs.
  - On an RS hit, EX_ReadData1 takes WB_WriteData instead of ID_ReadData1.
  - Same rule for Rt: EX_ReadData2 takes WB_WriteData on an RT hit.
- Write-back bypass on hold: while Stall=1 and Flush=0, a WB hit against the held EX_Rs/EX_Rt (same conditions as on load) overwrites EX_ReadData1/EX_ReadData2. All other held fields are unchanged. A stall spanning a write-back therefore never leaves a stale operand.
- Register 0 is never bypassed; WB_WriteReg=0 is ignored.
- Both Rs and Rt hit the same WB register: both operands are updated.
- Bypass applies only to the data fields, never to control fields.
- Bypass is applied regardless of ID_Valid. With ID_Valid=0 all other fields still load as presented; downstream qualifies on EX_Valid.
- No combinational path from any input to any output.
- Reset mid-stall: contents are lost; after release the register holds a bubble until the next non-stalled edge.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs StallCount and FlushCount (CNT_W each).
  - StallCount increments on each edge with Stall=1, Flush=0.
  - FlushCount increments on each edge with Flush=1.
  - Both saturate at all-ones and clear on reset.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - DATA_W, REG_ADDR_W and ALUOP_W defaults.
  - The ALUOp encodings.
  - A packed control-bundle typedef of the six control bits plus ALUOp.
  - The BUBBLE_CTRL all-zero constant.
- Sub-module wb_bypass_sel (compare WB_WriteReg against one specifier and select data), instantiated twice, once for Rs and once for Rt.

Test Plan:
- Reset: with Reset_n=0 mid-cycle, all EX_* are 0 before the next Clk edge. Release it; load ID_ReadData2=0x0000_0005, ID_Imm=0xFFFF_FFFC, ID_ALUSrc=1 → the next edge shows these values on EX_ReadData2, EX_Imm and EX_ALUSrc.
- Stall: hold Stall=1 for 3 cycles while ID inputs change → EX_* stays frozen, then updates 1 cycle after Stall drops.
- Flush with stall: Flush=1 and Stall=1 on the same edge with ID_RegWrite=1 → EX_RegWrite=0, EX_Valid=0, EX_ReadData1=0.
- Bypass on load: ID_Rs=8, ID_ReadData1=0x1111_1111, WB_RegWrite=1, WB_WriteReg=8, WB_WriteData=0xDEAD_BEEF → EX_ReadData1=0xDEAD_BEEF. Repeat with WB_WriteReg=0 → EX_ReadData1=0x1111_1111.
- Bypass on hold: stall with EX_Rt=9, then pulse WB_WriteReg=9, WB_WriteData=0x0000_00AA → EX_ReadData2=0x0000_00AA while stalled; EX_Imm is unchanged. Both-hit case (Rs=Rt=9) → both operands update.
- With ID_EX_PERF_CNT_EN: 5 stall edges and 2 flush edges → StallCount=5, FlushCount=2. Preload StallCount to all-ones → it holds at all-ones on further stalls.
